// File: rtl/lut_sel_mux.sv
// Registered, table-programmable bit selector with valid/ready output and a SCAN serialiser.
// Optional table read port is enabled by defining LUT_SEL_CFG_READBACK_EN.
module lut_sel_mux #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned IDX_W = $clog2(IN_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [SEL_W-1:0]     cfg_addr,
    input  logic [2+IDX_W-1:0]   cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      inp,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 scan_start,
    output logic                 out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
`ifdef LUT_SEL_CFG_READBACK_EN
    ,
    input  logic [SEL_W-1:0]     cfg_raddr,
    output logic [2+IDX_W-1:0]   cfg_rdata
`endif
);

    localparam int unsigned EW    = 2 + IDX_W;
    localparam int unsigned Depth = 2 ** SEL_W;
    localparam logic [SEL_W:0] LastCnt = (SEL_W + 1)'(Depth - 1);
    localparam logic [SEL_W:0] CntOne  = (SEL_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e              state_q, state_d;
    logic [EW-1:0]       tbl_q [Depth];
    logic [SEL_W:0]      cnt_q, cnt_d;
    logic [IN_W-1:0]     cap_q, cap_d;
    logic                out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                adv;

    // Out-of-range index forces 0 for both plain and inverted input modes.
    function automatic logic lut_eval(input logic [EW-1:0] ent, input logic [IN_W-1:0] word);
        logic [IDX_W-1:0] idx;
        logic             in_rng;
        logic             res;
        idx    = ent[IDX_W-1:0];
        in_rng = (32'(idx) < IN_W);
        case (ent[EW-1 -: 2])
            2'b00:   res = 1'b0;
            2'b01:   res = 1'b1;
            2'b10:   res = in_rng & word[idx];
            default: res = in_rng & ~word[idx];
        endcase
        return res;
    endfunction

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = (state_q == StIdle) && adv && !scan_start;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (adv) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (scan_start) begin
                    state_d = StScan;
                    cap_d   = inp;
                    cnt_d   = '0;
                end else if (in_valid && in_ready) begin
                    out_d       = lut_eval(tbl_q[sel], inp);
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end
            StScan: begin
                if (adv) begin
                    out_d       = lut_eval(tbl_q[cnt_q[SEL_W-1:0]], cap_q);
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == LastCnt);
                    cnt_d       = cnt_q + CntOne;
                    if (cnt_q == LastCnt) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cap_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Lookups in the write cycle read the pre-write entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

`ifdef LUT_SEL_CFG_READBACK_EN
    assign cfg_rdata = tbl_q[cfg_raddr];
`else
    // Table is write-only in this build.
`endif

endmodule

// File: tb/tb_lut_sel_mux.sv
// Directed self-checking bench for lut_sel_mux (default parameters).
module tb_lut_sel_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] inp;
    logic [2:0] sel;
    logic       scan_start;
    logic       out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
`ifdef LUT_SEL_CFG_READBACK_EN
    logic [2:0] cfg_raddr = 3'd0;
    logic [3:0] cfg_rdata;
`endif

    int n_checks = 0;
    int n_errors = 0;

    lut_sel_mux dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inp        (inp),
        .sel        (sel),
        .scan_start (scan_start),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
`ifdef LUT_SEL_CFG_READBACK_EN
        ,
        .cfg_raddr  (cfg_raddr),
        .cfg_rdata  (cfg_rdata)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] legacy [8];
        logic       scan_exp [8];
        legacy   = '{4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0100, 4'b1011};
        scan_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; inp = '0; sel = '0; scan_start = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Unprogrammed table reads const0
        in_valid = 1'b1; sel = 3'd5; inp = 4'b1111;
        tick();
        in_valid = 1'b0;
        check("t1_out", out, 0);
        check("t1_valid", out_valid, 1);
        check("t1_last", out_last, 0);
        tick();
        check("t1_drained", out_valid, 0);

        // Back-to-back lookups
        cfg_write(3'd2, 4'b1011);
        cfg_write(3'd6, 4'b0100);
        inp = 4'b1001; sel = 3'd2; in_valid = 1'b1;
        tick();
        check("t2_out_a", out, 1);
        check("t2_valid_a", out_valid, 1);
        sel = 3'd6;
        tick();
        check("t2_out_b", out, 1);
        check("t2_valid_b", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("t2_drained", out_valid, 0);

        // Backpressure hold
        cfg_write(3'd3, 4'b1100);
        out_ready = 1'b0; sel = 3'd3; in_valid = 1'b1;
        tick();
        check("t3_out", out, 0);
        check("t3_valid", out_valid, 1);
        sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            check("t3_in_ready", in_ready, 0);
            tick();
            check("t3_hold_out", out, 0);
            check("t3_hold_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("t3_released", out_valid, 0);

        // Write and lookup of the same entry in one cycle
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 4'b0100;
        sel = 3'd1; inp = 4'b1001; in_valid = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("t4_old_entry", out, 0);
        check("t4_valid", out_valid, 1);
        tick();
        check("t4_new_entry", out, 1);
        in_valid = 1'b0;
        tick();

        // Full scan of the legacy map
        for (int i = 0; i < 8; i++) cfg_write(3'(i), legacy[i]);
        inp = 4'b1001; scan_start = 1'b1; in_valid = 1'b1; sel = 3'd6;
        tick();
        scan_start = 1'b0; in_valid = 1'b0; inp = 4'b0000;
        check("t5_busy", busy, 1);
        check("t5_no_accept", out_valid, 0);
        check("t5_in_ready", in_ready, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t5_bit%0d", i), out, scan_exp[i]);
            check($sformatf("t5_valid%0d", i), out_valid, 1);
            check($sformatf("t5_last%0d", i), out_last, (i == 7));
            check($sformatf("t5_busy%0d", i), busy, 1);
        end
        tick();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_valid", out_valid, 0);
        check("t5_idle_in_ready", in_ready, 1);

        // Reset mid-scan
        inp = 4'b1001; scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t6_bit2", out, 1);
        check("t6_bit2_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_out", out, 0);
        check("t6_rst_last", out_last, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; sel = 3'd6; inp = 4'b1111;
        tick();
        check("t6_sel6_out", out, 0);
        check("t6_sel6_valid", out_valid, 1);
        check("t6_sel6_last", out_last, 0);
        sel = 3'd2;
        tick();
        check("t6_sel2_out", out, 0);
        in_valid = 1'b0;
        tick();
        check("t6_drained", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
